// File: rtl/v_pkg.sv
// rtl/v_pkg.sv - shared unit codes, FSM state and held-instruction type for the vector issue controller
//
// Purpose: common definitions imported by v_scoreboard and v_issue_ctrl.
// Ports:   none (package).

package v_pkg;

  localparam int NUM_UNITS = 5;

  localparam logic [2:0] UNIT_VALU    = 3'd0;
  localparam logic [2:0] UNIT_VMUL    = 3'd1;
  localparam logic [2:0] UNIT_VRED    = 3'd2;
  localparam logic [2:0] UNIT_VSLDU   = 3'd3;
  localparam logic [2:0] UNIT_VLSU    = 3'd4;
  localparam logic [2:0] UNIT_VCONFIG = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] unit;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic       rd_vs1;
    logic       rd_vs2;
    logic       wr_vd;
  } hold_t;

  // Codes 6 and 7 name no unit.
  function automatic logic unit_legal(input logic [2:0] u);
    return (u <= UNIT_VCONFIG);
  endfunction

endpackage

// File: rtl/v_scoreboard.sv
// rtl/v_scoreboard.sv - pending-register and busy-unit tracking with hazard query
//
// Purpose: tracks which vector registers await a write (pend), which units are
//          busy (unit_act) and which register each busy unit will write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   set_en/set_unit/set_vd/set_wr   record an issue (VCONFIG ignored)
//   unit_done[4:0]           completion pulses, bit = unit code
//   q_*                      instruction being checked for hazards
//   q_hazard                 unit busy, RAW or WAW against registered state
//   pend_any, act_any        any register pending / any unit busy
//   spur_done                done pulse on a unit that is not busy

module v_scoreboard
  import v_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [2:0]           set_unit,
  input  logic [4:0]           set_vd,
  input  logic                 set_wr,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic [2:0]           q_unit,
  input  logic [4:0]           q_vd,
  input  logic [4:0]           q_vs1,
  input  logic [4:0]           q_vs2,
  input  logic                 q_rd_vs1,
  input  logic                 q_rd_vs2,
  input  logic                 q_wr_vd,
  output logic                 q_hazard,
  output logic                 pend_any,
  output logic                 act_any,
  output logic                 spur_done
);

  logic [31:0]                pend_q, pend_d;
  logic [NUM_UNITS-1:0]       act_q, act_d;
  logic [NUM_UNITS-1:0]       wr_q, wr_d;
  logic [NUM_UNITS-1:0][4:0]  vd_q, vd_d;

  // Completions clear first, then the new issue sets, so a register both
  // released and claimed in the same cycle ends up pending.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    wr_d   = wr_q;
    vd_d   = vd_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_done[u] && act_q[u]) begin
        act_d[u] = 1'b0;
        if (wr_q[u]) pend_d[vd_q[u]] = 1'b0;
      end
    end
    if (set_en && (set_unit < UNIT_VCONFIG)) begin
      act_d[set_unit] = 1'b1;
      wr_d[set_unit]  = set_wr;
      vd_d[set_unit]  = set_vd;
      if (set_wr) pend_d[set_vd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      act_q  <= '0;
      wr_q   <= '0;
      vd_q   <= '0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      wr_q   <= wr_d;
      vd_q   <= vd_d;
    end
  end

  // Only registered state is consulted: a done seen this cycle frees
  // resources for the next cycle, never the current one.
  always_comb begin
    q_hazard = 1'b0;
    if (q_unit == UNIT_VCONFIG) begin
      q_hazard = (pend_q != '0) || (act_q != '0);
    end else begin
      if (q_unit < UNIT_VCONFIG) q_hazard = act_q[q_unit];
      if (q_rd_vs1 && pend_q[q_vs1]) q_hazard = 1'b1;
      if (q_rd_vs2 && pend_q[q_vs2]) q_hazard = 1'b1;
      if (q_wr_vd  && pend_q[q_vd])  q_hazard = 1'b1;
    end
  end

  assign pend_any  = (pend_q != '0);
  assign act_any   = (act_q != '0);
  assign spur_done = |(unit_done & ~act_q);

endmodule

// File: rtl/v_issue_ctrl.sv
// rtl/v_issue_ctrl.sv - single-entry vector instruction issue controller with hazard tracking
//
// Purpose: accepts one decoded instruction at a time, holds it until its unit
//          is free and no RAW/WAW hazard exists, then pulses the unit start.
// Optional: V_ISSUE_PERF_CNT_EN adds stall_cnt/issue_cnt saturating counters.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready                 instruction handshake
//   in_unit, in_vd/vs1/vs2, in_rd_vs1/in_rd_vs2/in_wr_vd   instruction fields
//   unit_done[4:0]                    completion pulses per unit
//   unit_start[4:0], cfg_start        one-cycle issue pulses
//   iss_vd/vs1/vs2                    fields of the instruction being issued
//   idle, err                         quiescent flag, illegal/spurious pulse
//   stall_cnt, issue_cnt              performance counters (macro only)

module v_issue_ctrl
  import v_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_unit,
  input  logic [4:0]           in_vd,
  input  logic [4:0]           in_vs1,
  input  logic [4:0]           in_vs2,
  input  logic                 in_rd_vs1,
  input  logic                 in_rd_vs2,
  input  logic                 in_wr_vd,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [4:0]           iss_vd,
  output logic [4:0]           iss_vs1,
  output logic [4:0]           iss_vs2,
  output logic                 cfg_start,
  output logic                 idle,
  output logic                 err
`ifdef V_ISSUE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     issue_cnt
`endif
);

  state_e state_q, state_d;
  hold_t  hold_q, hold_d;

  logic accept;
  logic legal;
  logic issue;
  logic hazard;
  logic pend_any;
  logic act_any;
  logic spur_done;

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign legal    = unit_legal(in_unit);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    issue      = 1'b0;
    unit_start = '0;
    cfg_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Illegal codes are dropped here; err reports them below.
        if (accept && legal) begin
          state_d = ST_HOLD;
          hold_d  = '{unit:   in_unit,
                      vd:     in_vd,
                      vs1:    in_vs1,
                      vs2:    in_vs2,
                      rd_vs1: in_rd_vs1,
                      rd_vs2: in_rd_vs2,
                      wr_vd:  in_wr_vd};
        end
      end
      ST_HOLD: begin
        if (!hazard && !rst) begin
          issue   = 1'b1;
          state_d = ST_IDLE;
          if (hold_q.unit == UNIT_VCONFIG) cfg_start = 1'b1;
          else unit_start = NUM_UNITS'(1) << hold_q.unit;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  v_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue),
    .set_unit  (hold_q.unit),
    .set_vd    (hold_q.vd),
    .set_wr    (hold_q.wr_vd),
    .unit_done (unit_done),
    .q_unit    (hold_q.unit),
    .q_vd      (hold_q.vd),
    .q_vs1     (hold_q.vs1),
    .q_vs2     (hold_q.vs2),
    .q_rd_vs1  (hold_q.rd_vs1),
    .q_rd_vs2  (hold_q.rd_vs2),
    .q_wr_vd   (hold_q.wr_vd),
    .q_hazard  (hazard),
    .pend_any  (pend_any),
    .act_any   (act_any),
    .spur_done (spur_done)
  );

  assign iss_vd  = hold_q.vd;
  assign iss_vs1 = hold_q.vs1;
  assign iss_vs2 = hold_q.vs2;

  assign err  = !rst && ((accept && !legal) || spur_done);
  assign idle = rst || ((state_q == ST_IDLE) && !pend_any && !act_any);

`ifdef V_ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] issue_q, issue_d;

  always_comb begin
    stall_d = stall_q;
    issue_d = issue_q;
    if ((state_q == ST_HOLD) && !issue && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (issue && (issue_q != '1)) issue_d = issue_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      stall_q <= stall_d;
      issue_q <= issue_d;
    end
  end

  assign stall_cnt = stall_q;
  assign issue_cnt = issue_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb/tb_v_issue_ctrl.sv - table-driven self-checking bench for v_issue_ctrl

module tb_v_issue_ctrl;
  import v_pkg::*;

  localparam int TB_CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_unit = '0;
  logic [4:0] in_vd = '0, in_vs1 = '0, in_vs2 = '0;
  logic       in_rd_vs1 = 1'b0, in_rd_vs2 = 1'b0, in_wr_vd = 1'b0;
  logic [4:0] unit_done = '0;
  logic [4:0] unit_start;
  logic [4:0] iss_vd, iss_vs1, iss_vs2;
  logic       cfg_start, idle, err;
`ifdef V_ISSUE_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt, issue_cnt;
`endif

  always #5 clk = ~clk;

  v_issue_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_unit    (in_unit),
    .in_vd      (in_vd),
    .in_vs1     (in_vs1),
    .in_vs2     (in_vs2),
    .in_rd_vs1  (in_rd_vs1),
    .in_rd_vs2  (in_rd_vs2),
    .in_wr_vd   (in_wr_vd),
    .unit_done  (unit_done),
    .unit_start (unit_start),
    .iss_vd     (iss_vd),
    .iss_vs1    (iss_vs1),
    .iss_vs2    (iss_vs2),
    .cfg_start  (cfg_start),
    .idle       (idle),
    .err        (err)
`ifdef V_ISSUE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .issue_cnt  (issue_cnt)
`endif
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] unit;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic       rd1;
    logic       wr;
    logic [4:0] done;
    logic [4:0] e_us;
    logic       e_cfg;
    logic       e_err;
    logic       e_rdy;
    logic       e_idle;
    logic [4:0] e_vd;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    input logic r, input logic v, input logic [2:0] u, input logic [4:0] vd,
    input logic [4:0] vs1, input logic rd1, input logic wr, input logic [4:0] dn,
    input logic [4:0] us, input logic cfg, input logic er, input logic rdy,
    input logic idl, input logic [4:0] evd);
    vec_t t;
    t.rst = r;  t.vld = v;  t.unit = u;  t.vd = vd;  t.vs1 = vs1;
    t.rd1 = rd1; t.wr = wr; t.done = dn;
    t.e_us = us; t.e_cfg = cfg; t.e_err = er; t.e_rdy = rdy; t.e_idle = idl; t.e_vd = evd;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] u, input logic [4:0] vd,
                       input logic [4:0] vs1, input logic rd1, input logic wr, input logic [4:0] dn);
    rst = r; in_valid = v; in_unit = u; in_vd = vd; in_vs1 = vs1; in_vs2 = '0;
    in_rd_vs1 = rd1; in_rd_vs2 = 1'b0; in_wr_vd = wr; unit_done = dn;
  endtask

  // Drive for one cycle and advance to just after the next rising edge.
  task automatic cyc(input logic r, input logic v, input logic [2:0] u, input logic [4:0] vd,
                     input logic [4:0] vs1, input logic rd1, input logic wr, input logic [4:0] dn);
    drive(r, v, u, vd, vs1, rd1, wr, dn);
    @(posedge clk); #1;
  endtask

  initial begin
    //            rst vld unit          vd     vs1    rd wr done      e_us      cfg err rdy idl e_vd
    tbl.push_back(mk(1, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 0, 1, 5'd0));  // in reset
    tbl.push_back(mk(0, 1, UNIT_VALU,   5'd3,  5'd0,  0, 1, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));  // accept VALU vd3
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00001, 0, 0, 0, 0, 5'd3));  // issue next cycle
    tbl.push_back(mk(0, 1, UNIT_VMUL,   5'd4,  5'd3,  1, 1, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'd0));  // VMUL reads v3
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'd0));  // RAW hold
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00001, 5'b00000, 0, 0, 0, 0, 5'd0));  // VALU done: not yet
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00010, 0, 0, 0, 0, 5'd4));  // VMUL issues
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00010, 5'b00000, 0, 0, 1, 0, 5'd0));  // VMUL done
    tbl.push_back(mk(0, 1, UNIT_VLSU,   5'd7,  5'd0,  0, 1, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));  // idle again
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b10000, 0, 0, 0, 0, 5'd7));
    tbl.push_back(mk(0, 1, UNIT_VCONFIG,5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'd0));  // VLSU busy
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b10000, 5'b00000, 0, 0, 0, 0, 5'd0));  // done: not yet
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'd0));  // cfg_start
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));  // idle
    tbl.push_back(mk(0, 1, 3'd7,        5'd1,  5'd0,  0, 1, 5'b00000, 5'b00000, 0, 1, 1, 1, 5'd0));  // illegal unit
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));  // dropped
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00100, 5'b00000, 0, 1, 1, 1, 5'd0));  // spurious VRED done
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));
    tbl.push_back(mk(0, 1, UNIT_VALU,   5'd5,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));  // VALU, no write
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00001, 0, 0, 0, 0, 5'd5));
    tbl.push_back(mk(0, 1, UNIT_VMUL,   5'd5,  5'd0,  0, 1, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00001, 5'b00010, 0, 0, 0, 0, 5'd5));  // issue + done same v5
    tbl.push_back(mk(0, 1, UNIT_VRED,   5'd6,  5'd5,  1, 1, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'd0));  // v5 still pending
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00010, 5'b00000, 0, 0, 0, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00100, 0, 0, 0, 0, 5'd6));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00100, 5'b00000, 0, 0, 1, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));
    tbl.push_back(mk(0, 1, UNIT_VSLDU,  5'd9,  5'd0,  0, 1, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b01000, 0, 0, 0, 0, 5'd9));
    tbl.push_back(mk(0, 1, UNIT_VSLDU,  5'd10, 5'd0,  0, 1, 5'b00000, 5'b00000, 0, 0, 1, 0, 5'd0));
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'd0));  // unit busy
    tbl.push_back(mk(1, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 0, 1, 5'd0));  // reset mid-op
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));  // all cleared
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b01000, 5'b00000, 0, 1, 1, 1, 5'd0));  // late VSLDU done
    tbl.push_back(mk(0, 0, 3'd0,        5'd0,  5'd0,  0, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 5'd0));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].unit, tbl[i].vd, tbl[i].vs1, tbl[i].rd1, tbl[i].wr, tbl[i].done);
      #4;
      chk("unit_start", i, 32'(unit_start), 32'(tbl[i].e_us));
      chk("cfg_start",  i, 32'(cfg_start),  32'(tbl[i].e_cfg));
      chk("err",        i, 32'(err),        32'(tbl[i].e_err));
      chk("in_ready",   i, 32'(in_ready),   32'(tbl[i].e_rdy));
      chk("idle",       i, 32'(idle),       32'(tbl[i].e_idle));
      if ((tbl[i].e_us != '0) || tbl[i].e_cfg) chk("iss_vd", i, 32'(iss_vd), 32'(tbl[i].e_vd));
      @(posedge clk); #1;
    end

`ifdef V_ISSUE_PERF_CNT_EN
    cyc(1, 0, 3'd0, 5'd0, 5'd0, 0, 0, 5'b00000);
    #4;
    chk("stall_cnt_rst", 100, 32'(stall_cnt), 32'd0);
    chk("issue_cnt_rst", 100, 32'(issue_cnt), 32'd0);
    #1;
    cyc(0, 1, UNIT_VALU, 5'd1, 5'd0, 0, 1, 5'b00000);  // accept
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00000);  // issue
    #4;
    chk("issue_cnt_first", 101, 32'(issue_cnt), 32'd1);
    chk("stall_cnt_none",  101, 32'(stall_cnt), 32'd0);
    #1;
    cyc(0, 1, UNIT_VMUL, 5'd2, 5'd1, 1, 1, 5'b00000);  // accept, RAW on v1
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00000);  // stall 1
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00000);  // stall 2
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00001);  // stall 3, VALU done
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00000);  // issue
    #4;
    chk("stall_cnt_three", 102, 32'(stall_cnt), 32'd3);
    chk("issue_cnt_two",   102, 32'(issue_cnt), 32'd2);
    #1;
    cyc(0, 1, UNIT_VALU, 5'd3, 5'd0, 0, 1, 5'b00000);
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00000);  // third issue
    cyc(0, 1, UNIT_VMUL, 5'd8, 5'd0, 0, 1, 5'b00000);  // VMUL still busy
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00000);  // stall
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00010);  // stall, VMUL done
    cyc(0, 0, 3'd0,      5'd0, 5'd0, 0, 0, 5'b00000);  // fourth issue
    #4;
    chk("stall_cnt_sat", 103, 32'(stall_cnt), 32'd3);
    chk("issue_cnt_sat", 103, 32'(issue_cnt), 32'd3);
    #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
